switch_debounce4: RTL
=====================

SWITCH_DEBOUNCE4 -- requirements
Module: switch_debounce4

Interface
REQ-001 Parameter: DB_CYCLES, default 4; consecutive synchronized cycles a changed level must hold before it is accepted (legal range 2..65535).
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: sw_in  input  4  raw, asynchronous switch/button levels.
REQ-005 Port: sw_out  output  4  debounced levels; bits [0..3] drive the a,b,c,d inputs of the downstream AND-chain stage.
REQ-006 Port: rise  output  4  one-cycle pulse per channel when sw_out bit goes 0->1.
REQ-007 Port: fall  output  4  one-cycle pulse per channel when sw_out bit goes 1->0.
REQ-008 Port: chg  output  1  OR of all rise and fall bits, same cycle.
REQ-009 The block has one clock and a synchronous, active-high reset; no other clock or reset domain exists.

Function
REQ-010 Each sw_in bit SHALL pass through a two-flop synchronizer (sync1 then sync2) before any other use.
REQ-011 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each debounce on their own timeline.
REQ-012 Each channel SHALL have a counter of width ceil(log2(DB_CYCLES)) bits.
REQ-013 At an edge where sync2 equals sw_out, the counter SHALL clear to 0.
REQ-014 At an edge where sync2 differs from sw_out and the counter is below DB_CYCLES-1, the counter SHALL increment by 1.
REQ-015 At an edge where sync2 differs from sw_out and the counter equals DB_CYCLES-1, sw_out SHALL take the sync2 value and the counter SHALL clear to 0.
REQ-016 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-017 Latency: a clean level change first sampled at edge E0 SHALL appear on sw_out after edge E0+DB_CYCLES+1, i.e. the (DB_CYCLES+2)th sampling edge.
REQ-018 A raw pulse held for DB_CYCLES-1 or fewer sampled cycles SHALL be rejected: no sw_out change and no pulses.
REQ-019 A raw pulse held for exactly DB_CYCLES sampled cycles SHALL be accepted.
REQ-020 rise[i]/fall[i] SHALL be registered and high for exactly the single cycle in which sw_out[i] first shows its new value.
REQ-021 rise[i] and fall[i] SHALL never be high together; chg SHALL be high exactly when any rise or fall bit is high.
REQ-022 Bounce, i.e. toggling of sync2 before acceptance, SHALL restart the count from 0 on the first matching edge.

Reset
REQ-023 While rst is high at a rising edge, sync1, sync2, all counters, sw_out, rise, fall and chg SHALL become 0.
REQ-024 Reset asserted mid-count SHALL abandon the count; no pulse SHALL be emitted for the abandoned change.
REQ-025 After rst deasserts, a sw_in bit already held at 1 SHALL be accepted as a normal 0->1 change, with a rise pulse at REQ-017 latency.

Structure
REQ-026 A shared package SHALL hold the channel count constant (4), the DB_CYCLES default, and the counter-width function.
REQ-027 One sub-module, debounce_channel, SHALL implement the synchronizer, counter and edge pulses for one bit.
REQ-028 The top level SHALL instantiate debounce_channel four times and OR the pulses into chg.
REQ-029 Expected RTL size is 120-250 lines in total; no latches; no combinational path from sw_in to any output.

Verification (DB_CYCLES=4)
REQ-030 Reset release with sw_in=4'b0000 -> all outputs 0 for 20 cycles.
REQ-031 sw_in[0] 0->1 sampled at E0 and held -> sw_out=4'b0001 after E5; rise=4'b0001 and chg=1 for that one cycle only; no further pulses.
REQ-032 sw_in[2] high for 3 sampled cycles, then low -> sw_out, rise, fall and chg stay 0 throughout.
REQ-033 sw_in[2] high for 4 sampled cycles -> sw_out[2]=1 after E5 with one rise pulse; return to 0 after the raw low settles, with one fall pulse.
REQ-034 sw_in=4'b1111 on one edge -> all four sw_out bits rise in the same cycle with rise=4'b1111, then downstream AND-chain inputs a,b,c,d all read 1.
REQ-035 rst pulsed at count=2 with sw_in[1]=1 held -> no pulse during reset; after release, rise[1] appears after the (DB_CYCLES+2)th edge following release.

Source files
------------

// File: rtl/switch_debounce4_pkg.sv
// ---------------------------------------------------------------------------
// switch_debounce4_pkg
// Shared constants for the four-channel switch debouncer:
//   NUM_CH            - number of independent switch channels
//   DB_CYCLES_DEFAULT - default number of stable cycles before a level is
//                       accepted
//   cnt_width()       - width of the per-channel stability counter
// ---------------------------------------------------------------------------
package switch_debounce4_pkg;

   localparam int NUM_CH            = 4;
   localparam int DB_CYCLES_DEFAULT = 4;

   // The counter only ever has to hold 0..db-1, so ceil(log2(db)) bits are
   // enough. The floor of 1 keeps the vector legal for the smallest settings.
   function automatic int cnt_width(input int db);
      int w;
      w = $clog2(db);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/switch_debounce4_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debounced switch channel: two-flop synchronizer, stability counter and
// registered edge pulses.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   raw   - asynchronous raw switch level
//   level - debounced level
//   rise  - one-cycle pulse when level goes 0->1
//   fall  - one-cycle pulse when level goes 1->0
// ---------------------------------------------------------------------------
module debounce_channel
   import switch_debounce4_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int               CW      = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0]    CNT_MAX = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // The counter measures how many consecutive edges the synchronized level
   // has disagreed with the accepted level. Any agreement (including a bounce
   // back) clears it, so only an uninterrupted run of DB_CYCLES disagreeing
   // edges is accepted. The pulse is raised on the same edge that updates
   // level, so it is visible exactly in the first cycle of the new value.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_debounce4.sv
// ---------------------------------------------------------------------------
// switch_debounce4
// Four independent switch debouncers with per-channel edge pulses.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   sw_in  - raw asynchronous switch levels
//   sw_out - debounced levels (bits 0..3 feed the downstream a,b,c,d inputs)
//   rise   - per-channel one-cycle 0->1 pulse
//   fall   - per-channel one-cycle 1->0 pulse
//   chg    - high whenever any rise or fall bit is high
// ---------------------------------------------------------------------------
module switch_debounce4
   import switch_debounce4_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] sw_in,
   output logic [NUM_CH-1:0] sw_out,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic              chg
);

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      debounce_channel #(
         .DB_CYCLES(DB_CYCLES)
      ) u_channel (
         .clk  (clk),
         .rst  (rst),
         .raw  (sw_in[ch]),
         .level(sw_out[ch]),
         .rise (rise[ch]),
         .fall (fall[ch])
      );
   end

   // Pulses are already registered inside each channel, so this OR adds no
   // path from sw_in and lines chg up with the pulses in the same cycle.
   assign chg = |{rise, fall};

endmodule
